// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, stall patterns and FSM state type for pipe_ctrl
package pipe_ctrl_pkg;

    localparam logic        STOP        = 1'b1;
    localparam logic        NOT_STOP    = 1'b0;
    localparam int          STALL_BUS_W = 6;
    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    // Bit 5 (WB) is never stopped so the instruction in WB always retires.
    localparam stall_bus_t STALL_FROM_MEM = {NOT_STOP, STOP, STOP, STOP, STOP, STOP};
    localparam stall_bus_t STALL_FROM_EX  = {NOT_STOP, NOT_STOP, STOP, STOP, STOP, STOP};
    localparam stall_bus_t STALL_FROM_ID  = {NOT_STOP, NOT_STOP, NOT_STOP, STOP, STOP, STOP};
    localparam stall_bus_t STALL_NONE     = {STALL_BUS_W{NOT_STOP}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic stall_bus_t stall_pattern(input logic req_mem,
                                                 input logic req_ex,
                                                 input logic req_id);
        if (req_mem)
            return STALL_FROM_MEM;
        else if (req_ex)
            return STALL_FROM_EX;
        else if (req_id)
            return STALL_FROM_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// rtl/pipe_ctrl_stall_watchdog.sv - consecutive-stall run counter with sticky timeout flag
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall_active,
    input  logic i_flush,
    output logic o_timeout
);

    localparam int              RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] LIMIT = RUN_W'(TIMEOUT);

    logic [RUN_W-1:0] r_run_cnt;
    logic [RUN_W-1:0] w_run_next;
    logic             r_timeout;

    always_comb begin
        w_run_next = r_run_cnt;
        if (i_flush || !i_stall_active)
            w_run_next = '0;
        else if (r_run_cnt != LIMIT)
            w_run_next = r_run_cnt + 1'b1;
    end

    // Flag is set on the same edge that carries the counter to the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_run_cnt <= w_run_next;
            if (w_run_next == LIMIT)
                r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, exception flush sequencer and stall statistics
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excep_req,
    input  logic [31:0]      excep_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t           r_state;
    logic             r_flush;
    logic [31:0]      r_new_pc;
    logic [CNT_W-1:0] r_stall_cycles;
    stall_bus_t       w_stall;
    logic             w_stall_active;
    logic             w_timeout;

    // Exception and flush both suppress stalls so the flush lands on a moving pipe.
    always_comb begin
        w_stall = STALL_NONE;
        if (rst == RST_ENABLE)
            w_stall = STALL_NONE;
        else if (r_state == ST_FLUSH)
            w_stall = STALL_NONE;
        else if (excep_req)
            w_stall = STALL_NONE;
        else
            w_stall = stall_pattern(stallreq_mem, stallreq_ex, stallreq_id);
    end

    assign w_stall_active = (w_stall != STALL_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_flush  <= 1'b0;
            r_new_pc <= ZERO_WORD;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (excep_req) begin
                        r_state  <= ST_FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= excep_pc;
                    end else begin
                        r_flush  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_stall_active && (r_stall_cycles != {CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    pipe_ctrl_stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_watchdog (
        .clk            (clk),
        .rst            (rst),
        .i_stall_active (w_stall_active),
        .i_flush        (r_flush),
        .o_timeout      (w_timeout)
    );

    assign stall         = w_stall;
    assign flush         = r_flush;
    assign new_pc        = r_new_pc;
    assign stall_timeout = w_timeout;
    assign stall_cycles  = r_stall_cycles;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the six-stage CPU (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the `stall` bus consumed by every pipeline register. It sequences a one-cycle exception flush with redirect PC. It also keeps stall statistics and a stall watchdog. It sits beside the pipeline registers (pc_reg … mem_wb) and drives their `stall` and `flush` inputs.

## Interface
Parameters:
- `TIMEOUT`, default 1024: consecutive stalled cycles before `stall_timeout` sets.
- `CNT_W`, default 32: width of `stall_cycles`.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `stallreq_id`  input  1  ID requests stall (load-use hazard).
- `stallreq_ex`  input  1  EX requests stall (multi-cycle div/madd).
- `stallreq_mem`  input  1  MEM requests stall (data bus wait).
- `excep_req`  input  1  MEM-stage exception raised this cycle.
- `excep_pc`  input  32  handler address accompanying `excep_req`.
- `stall`  output  6  bit i = `Stop` freezes stage i (0=PC … 5=WB).
- `flush`  output  1  clears all pipeline registers to NOP.
- `new_pc`  output  32  redirect target, valid while `flush`=1.
- `stall_timeout`  output  1  sticky watchdog error.
- `stall_cycles`  output  CNT_W  saturating count of cycles with `stall`≠0.

## Operation
- FSM states:
  - `RUN`: normal.
  - `FLUSH`: one-cycle flush.
- `RUN` → `FLUSH` on a sampled `excep_req`=1.
- `FLUSH` → `RUN` unconditionally after one cycle.
- `stall` is combinational from the requests in `RUN`, priority mem > ex > id:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - none → 6'b000000
- The WB bit is never set, so the instruction in WB always retires, and MEM inserts a bubble into WB.
- `excep_req` in `RUN` overrides all stall requests:
  - `stall`=0 that cycle.
  - `excep_pc` is latched into `new_pc`.
  - FSM enters `FLUSH`.
- In `FLUSH`:
  - `flush`=1, `stall`=0.
  - `new_pc` holds the latched value.
  - All stall requests and `excep_req` are ignored; a request still high next cycle is honoured in `RUN`.
- Watchdog:
  - The run counter increments each cycle `stall`≠0 and clears when `stall`=0 or on `flush`.
  - When the run counter reaches `TIMEOUT`, `stall_timeout` sets; it clears only on `rst`.
  - The run counter saturates at `TIMEOUT`.
- `stall_cycles` increments each cycle `stall`≠0 and saturates at all-ones.

## Timing
- `stall` has zero latency: it is valid in the same cycle as the requests.
- `flush`/`new_pc` have one-cycle latency: `excep_req` sampled at edge N gives `flush`=1 during cycle N+1, for exactly one cycle.
- Back-to-back `excep_req` in consecutive cycles: the second is dropped, because it arrives during `FLUSH`.
- Reset values:
  - FSM=`RUN`, `flush`=0, `new_pc`=0.
  - `stall_timeout`=0, `stall_cycles`=0, run counter=0.
  - `stall` reads 0 while `rst`=1, regardless of requests.
- Reset mid-`FLUSH`: outputs return to their reset values immediately (asynchronously); no flush completes after release.
- Watchdog timing: with `stall`≠0 continuously from cycle 1, `stall_timeout` rises after the `TIMEOUT`-th stalled cycle's edge.

## Structure
- Shared `defines.v` holds:
  - `Stop`/`NotStop`, `StallBus`, `RstEnable`, `ZeroWord`.
  - New stall pattern constants `StallFromMem`, `StallFromEx`, `StallFromId`, `StallNone`.
- Sub-module `stall_watchdog` contains the run counter, the `TIMEOUT` compare and the sticky flag.
- The FSM, stall priority logic and statistics counter stay in `pipe_ctrl`.

## Test plan
- Priority: `stallreq_id`=1 and `stallreq_ex`=1 → `stall`=6'b001111; add `stallreq_mem`=1 → 6'b011111; drop all → 6'b000000 the same cycle.
- Exception over stall: `stallreq_mem`=1 with `excep_req`=1 and `excep_pc`=32'h0000_0020 at cycle 5 →
  - cycle 5: `stall`=0.
  - cycle 6: `flush`=1, `new_pc`=32'h20, `stall`=0 while `stallreq_mem` is still held.
  - cycle 7: `flush`=0, `stall`=6'b011111.
- Back-to-back exceptions: `excep_req`=1 for 2 cycles with `excep_pc` 32'h20 then 32'h40 → single `flush` pulse with `new_pc`=32'h20.
- Watchdog: `TIMEOUT`=8, `stallreq_ex` held 8 cycles → `stall_timeout` rises after the 8th edge. With 7 cycles, release, then 7 more cycles → it stays 0. Once set, it stays 1 until `rst`.
- Counter: 3 stalled cycles, 2 idle, 4 stalled → `stall_cycles`=7. With `CNT_W`=3, 9 stalled cycles → it saturates at 7.
- Reset: assert `rst` asynchronously between edges during `FLUSH` → `flush`, `new_pc` and `stall_timeout` go to 0 immediately, `stall`=0 while `rst`=1, and FSM is in `RUN` after release.
